race_initiator: RTL and testbench

//  Requesting end of the start/done race handshake. Takes one job at a time from an

---
 rtl/race_pkg.sv | 21 ++
 rtl/race_initiator_if.sv | 54 +++++
 rtl/race_lat_counter.sv | 52 +++++
 rtl/race_initiator.sv | 149 ++++++++++++++
 tb/tb_race_initiator.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/race_pkg.sv
// ----------------------------------------------------------------------------
// race_pkg
// Shared definitions for both ends of the start/done race handshake:
//   - race_state_e : initiator FSM encoding (2 bits, one code unused)
//   - RACE_*       : default widths, timeout and start-low gap length
// No ports; imported by the initiator, its interface and its sub-modules.
// ----------------------------------------------------------------------------
package race_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } race_state_e;

    localparam int RACE_LAT_W      = 8;
    localparam int RACE_TIMEOUT    = 200;
    localparam int RACE_GAP_CYCLES = 1;
    localparam int RACE_CNT_W      = 16;

endpackage

// File: rtl/race_initiator_if.sv
// ----------------------------------------------------------------------------
// race_initiator_if
// Bundles the initiator's upstream request port, the start/done link to the
// responder and the completion/status outputs.
//   master : the initiator (drives req_ready, start, rsp_*, stale_done, busy,
//            txn_count; samples req_valid, done)
//   slave  : the environment (upstream requester + responder)
// Parameters LAT_W / CNT_W must match the initiator instance.
// ----------------------------------------------------------------------------
interface race_initiator_if
    import race_pkg::*;
#(
    parameter int LAT_W = RACE_LAT_W,
    parameter int CNT_W = RACE_CNT_W
);

    logic             req_valid;
    logic             req_ready;
    logic             start;
    logic             done;
    logic             rsp_valid;
    logic [LAT_W-1:0] rsp_latency;
    logic             rsp_timeout;
    logic             stale_done;
    logic             busy;
    logic [CNT_W-1:0] txn_count;

    modport master (
        input  req_valid,
        input  done,
        output req_ready,
        output start,
        output rsp_valid,
        output rsp_latency,
        output rsp_timeout,
        output stale_done,
        output busy,
        output txn_count
    );

    modport slave (
        output req_valid,
        output done,
        input  req_ready,
        input  start,
        input  rsp_valid,
        input  rsp_latency,
        input  rsp_timeout,
        input  stale_done,
        input  busy,
        input  txn_count
    );

endinterface

// File: rtl/race_lat_counter.sv
// ----------------------------------------------------------------------------
// race_lat_counter
// Latency counter with clear, increment, saturation and terminal-count flag.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   clr      : restart the count from zero this cycle
//   en       : add one (after clr, so clr & en loads 1)
//   cnt      : current count, saturates at all-ones
//   tc       : cnt equals TC_VAL
// ----------------------------------------------------------------------------
module race_lat_counter
    import race_pkg::*;
#(
    parameter int LAT_W  = RACE_LAT_W,
    parameter int TC_VAL = RACE_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [LAT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [LAT_W-1:0] CNT_MAX = '1;
    localparam logic [LAT_W-1:0] CNT_TC  = LAT_W'(TC_VAL);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] base;

    // clr and en together load 1: the accept edge itself is the first
    // counted edge of a measurement.
    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (en && (base != CNT_MAX)) begin
            cnt_d = base + LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CNT_TC);

endmodule

// File: rtl/race_initiator.sv
// ----------------------------------------------------------------------------
// race_initiator
// Requesting end of the start/done race handshake. Accepts one job at a time,
// holds start high until the responder's one-cycle done pulse (or a timeout),
// reports latency, then keeps start low for GAP_CYCLES+ cycles so the
// responder re-arms.
//   clk, rst : clock, synchronous active-high reset
//   bus      : race_initiator_if.master (request port, start/done, results)
// ----------------------------------------------------------------------------
module race_initiator
    import race_pkg::*;
#(
    parameter int LAT_W      = RACE_LAT_W,
    parameter int TIMEOUT    = RACE_TIMEOUT,
    parameter int GAP_CYCLES = RACE_GAP_CYCLES,
    parameter int CNT_W      = RACE_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    race_initiator_if.master   bus
);

    localparam int               GAP_W       = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(GAP_CYCLES);
    localparam logic [LAT_W-1:0] TIMEOUT_VAL = LAT_W'(TIMEOUT);

    race_state_e      state_q, state_d;
    logic             start_q, start_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [LAT_W-1:0] rsp_latency_q, rsp_latency_d;
    logic             stale_done_q, stale_done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             req_ready;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_en;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_tc;

    // Gated by rst so nothing looks acceptable while the block is held in reset.
    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = bus.req_valid && req_ready;

    race_lat_counter #(
        .LAT_W  (LAT_W),
        .TC_VAL (TIMEOUT)
    ) u_lat_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (lat_cnt),
        .tc  (lat_tc)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        rsp_latency_d = rsp_latency_q;
        stale_done_d  = 1'b0;
        txn_count_d   = txn_count_q;
        gap_d         = gap_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_d      = 1'b0;
                stale_done_d = bus.done;
                if (accept) begin
                    state_d = ST_REQ;
                    start_d = 1'b1;
                    cnt_clr = 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            ST_REQ: begin
                start_d = 1'b1;
                // A done landing on the timeout cycle still counts as a response.
                if (bus.done || lat_tc) begin
                    state_d       = ST_GAP;
                    start_d       = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = !bus.done;
                    rsp_latency_d = bus.done ? lat_cnt : TIMEOUT_VAL;
                    txn_count_d   = txn_count_q + CNT_W'(1);
                    gap_d         = GAP_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_GAP: begin
                start_d      = 1'b0;
                stale_done_d = bus.done;
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_REQ) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_latency_q <= '0;
            stale_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            txn_count_q   <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_latency_q <= rsp_latency_d;
            stale_done_q  <= stale_done_d;
            busy_q        <= busy_d;
            txn_count_q   <= txn_count_d;
            gap_q         <= gap_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.start       = start_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_latency = rsp_latency_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.stale_done  = stale_done_q;
    assign bus.busy        = busy_q;
    assign bus.txn_count   = txn_count_q;

endmodule

// File: tb/tb_race_initiator.sv
// ----------------------------------------------------------------------------
// tb_race_initiator
// Drives race_initiator through its request port with a behavioural responder
// whose done pulse comes D cycles after it first sees start (plus its own
// two-edge registration), and checks results against the handshake rules.
// ----------------------------------------------------------------------------
module tb_race_initiator;

    localparam int LAT_W      = 8;
    localparam int TIMEOUT    = 10;
    localparam int GAP_CYCLES = 1;
    localparam int CNT_W      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    race_initiator_if #(.LAT_W(LAT_W), .CNT_W(CNT_W)) bus();

    race_initiator #(
        .LAT_W      (LAT_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int d;
        int exp_lat;
        bit exp_to;
    } vec_t;

    int checks    = 0;
    int failures  = 0;
    int exp_count = 0;
    int rsp_delay = 0;
    bit rsp_cancel = 1'b1;
    bit inject_done = 1'b0;
    int stale_seen = 0;
    int rsp_seen   = 0;

    // Responder: sees start at a negedge, pulses done D+2 negedges later, so
    // the initiator samples done on the (D+3)th edge after it raised start.
    // With rsp_cancel set it abandons the job when start drops.
    initial begin : responder
        bit active;
        bit fired;
        int k;
        active = 1'b0;
        fired  = 1'b0;
        k      = 0;
        bus.done = 1'b0;
        forever begin
            @(negedge clk);
            bus.done    = inject_done;
            inject_done = 1'b0;
            if (active) begin
                k++;
                if (bus.start !== 1'b1 && rsp_cancel) begin
                    active = 1'b0;
                end else if (k == rsp_delay + 2) begin
                    bus.done = 1'b1;
                    active   = 1'b0;
                    fired    = 1'b1;
                end
            end else if (bus.start === 1'b1 && !fired) begin
                active = 1'b1;
                k      = 0;
            end
            if (bus.start !== 1'b1) fired = 1'b0;
        end
    end

    initial begin : pulse_monitor
        forever begin
            @(negedge clk);
            if (bus.stale_done === 1'b1) stale_seen++;
            if (bus.rsp_valid === 1'b1)  rsp_seen++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: done is sampled on edge D+3 unless the timeout edge comes first.
    function automatic int model_lat(input int d);
        return (d + 3 <= TIMEOUT) ? d + 3 : TIMEOUT;
    endfunction

    task automatic wait_ready(input string name);
        int cyc;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        check({name, "_ready"}, int'(bus.req_ready), 1);
    endtask

    task automatic run_txn(input string name, input int d, input bit cancel,
                           input int idle, input int exp_lat, input bit exp_to);
        int cyc;
        int hi;
        rsp_delay  = d;
        rsp_cancel = cancel;
        wait_ready(name);
        repeat (idle) tick();
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check({name, "_busy_in_req"}, int'(bus.busy), 1);
        check({name, "_ready_in_req"}, int'(bus.req_ready), 0);
        hi  = 0;
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 300) begin
            if (bus.start === 1'b1) hi++;
            tick();
            cyc++;
        end
        exp_count++;
        check({name, "_rsp_valid"}, int'(bus.rsp_valid), 1);
        check({name, "_latency"}, int'(bus.rsp_latency), exp_lat);
        check({name, "_timeout"}, int'(bus.rsp_timeout), int'(exp_to));
        check({name, "_start_high"}, hi, exp_lat);
        check({name, "_start_dropped"}, int'(bus.start), 0);
        check({name, "_txn_count"}, int'(bus.txn_count), exp_count);
        $display("txn %s: D=%0d latency=%0d timeout=%0d start_high=%0d count=%0d",
                 name, d, bus.rsp_latency, bus.rsp_timeout, hi, bus.txn_count);
    endtask

    initial begin : main
        vec_t vecs[7];
        int   c0, n_rsp, low_run, gap_low, cyc, s0, r0, d;
        bit   counting;

        vecs[0] = '{d: 0,  exp_lat: 3,  exp_to: 1'b0};
        vecs[1] = '{d: 1,  exp_lat: 4,  exp_to: 1'b0};
        vecs[2] = '{d: 5,  exp_lat: 8,  exp_to: 1'b0};
        vecs[3] = '{d: 7,  exp_lat: 10, exp_to: 1'b0};  // done on the timeout edge
        vecs[4] = '{d: 8,  exp_lat: 10, exp_to: 1'b1};
        vecs[5] = '{d: 12, exp_lat: 10, exp_to: 1'b1};
        vecs[6] = '{d: 3,  exp_lat: 6,  exp_to: 1'b0};

        // Reset held with a pending request.
        bus.req_valid = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_start", int'(bus.start), 0);
            check("rst_req_ready", int'(bus.req_ready), 0);
            check("rst_txn_count", int'(bus.txn_count), 0);
            check("rst_rsp_valid", int'(bus.rsp_valid), 0);
            check("rst_busy", int'(bus.busy), 0);
            check("rst_rsp_latency", int'(bus.rsp_latency), 0);
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_ready", int'(bus.req_ready), 1);
        check("post_rst_start", int'(bus.start), 0);

        // Table of single transactions.
        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].d, 1'b1, 0, vecs[i].exp_lat, vecs[i].exp_to);
        end

        // Back-to-back with req_valid held: start stays low for the gap plus
        // the IDLE accept cycle.
        rsp_delay  = 5;
        rsp_cancel = 1'b1;
        wait_ready("b2b");
        c0       = int'(bus.txn_count);
        n_rsp    = 0;
        low_run  = 0;
        gap_low  = -1;
        counting = 1'b0;
        cyc      = 0;
        bus.req_valid = 1'b1;
        while (n_rsp < 2 && cyc < 100) begin
            tick();
            cyc++;
            if (counting && bus.start === 1'b1) begin
                gap_low  = low_run;
                counting = 1'b0;
            end else if (counting) begin
                low_run++;
            end
            if (bus.rsp_valid === 1'b1) begin
                n_rsp++;
                check("b2b_latency", int'(bus.rsp_latency), model_lat(5));
                if (n_rsp == 1) begin
                    counting = 1'b1;
                    low_run  = 1;
                end
            end
        end
        bus.req_valid = 1'b0;
        exp_count += 2;
        check("b2b_done_count", n_rsp, 2);
        check("b2b_start_low_cycles", gap_low, GAP_CYCLES + 1);
        check("b2b_txn_count", int'(bus.txn_count), c0 + 2);
        $display("txn b2b: two back-to-back D=5, start low %0d cycles, count=%0d",
                 gap_low, bus.txn_count);

        // done during GAP is flagged as stale and does not disturb control.
        run_txn("gap_stale", 0, 1'b1, 0, 3, 1'b0);
        inject_done = 1'b1;
        tick();
        check("gap_stale_pulse", int'(bus.stale_done), 1);
        check("gap_stale_no_rsp", int'(bus.rsp_valid), 0);
        check("gap_stale_ready", int'(bus.req_ready), 1);
        tick();
        check("gap_stale_single", int'(bus.stale_done), 0);

        // Timeout, then the responder answers two cycles late.
        run_txn("late_done", 9, 1'b0, 0, 10, 1'b1);
        tick();
        check("late_before", int'(bus.stale_done), 0);
        tick();
        check("late_stale_pulse", int'(bus.stale_done), 1);
        check("late_no_rsp", int'(bus.rsp_valid), 0);
        check("late_idle_ready", int'(bus.req_ready), 1);
        tick();
        check("late_stale_single", int'(bus.stale_done), 0);
        check("late_txn_count", int'(bus.txn_count), exp_count);
        check("late_start_low", int'(bus.start), 0);

        // Randomised delays and idle spacing against the reference model.
        s0 = stale_seen;
        r0 = rsp_seen;
        for (int i = 0; i < 25; i++) begin
            d = int'($urandom_range(0, 12));
            run_txn($sformatf("rand%0d", i), d, 1'b1, int'($urandom_range(0, 3)),
                    model_lat(d), (d + 3 > TIMEOUT));
        end
        tick();
        tick();
        check("rand_rsp_pulses", rsp_seen - r0, 25);
        check("rand_no_stale", stale_seen - s0, 0);

        // Reset while in REQ with lat_cnt = 4.
        rsp_delay  = 50;
        rsp_cancel = 1'b1;
        wait_ready("mid_rst");
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (3) tick();
        check("mid_rst_start_before", int'(bus.start), 1);
        rst = 1'b1;
        tick();
        r0 = rsp_seen;
        check("mid_rst_start", int'(bus.start), 0);
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
        check("mid_rst_txn_count", int'(bus.txn_count), 0);
        rst = 1'b0;
        repeat (20) tick();
        check("mid_rst_no_rsp", rsp_seen - r0, 0);
        check("mid_rst_idle_ready", int'(bus.req_ready), 1);
        check("mid_rst_start_low", int'(bus.start), 0);
        check("mid_rst_latency", int'(bus.rsp_latency), 0);
        $display("txn mid_rst: reset in REQ, count=%0d", bus.txn_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
